// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, with sign fix-up and the divide special cases resolved at issue.
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   rs1Data_i,
    input  logic [XLEN-1:0]   rs2Data_i,
    input  logic [REG_AW-1:0] rdIn_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o,
    output logic [REG_AW-1:0] rdOut_o,
    output logic              wbEnable_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q;
    logic [CW-1:0]       count_q;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rdCap_q;
    logic [REG_AW-1:0]   rdOut_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic [XLEN-1:0]     addend_q;
    logic [XLEN-1:0]     result_q;
    logic                negRes_q;
    logic                negRem_q;

    logic [XLEN-1:0]     hi_d;
    logic [XLEN-1:0]     lo_d;
    logic [XLEN:0]       mulSum;
    logic [XLEN:0]       divShift;
    logic [XLEN:0]       divDiff;
    logic [2*XLEN-1:0]   prodFinal;
    logic [XLEN-1:0]     quoFinal;
    logic [XLEN-1:0]     remFinal;
    logic [XLEN-1:0]     finalRes;

    logic                aSigned;
    logic                bSigned;
    logic                aNeg;
    logic                bNeg;
    logic [XLEN-1:0]     aMag;
    logic [XLEN-1:0]     bMag;
    logic                divZero;
    logic                divOvf;
    logic [XLEN-1:0]     fastRes;

    // Issue-time decode: operand magnitudes, signs and the divide fast paths.
    always_comb begin
        aSigned = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010) ||
                  (op_i == 3'b100) || (op_i == 3'b110);
        bSigned = (op_i == 3'b000) || (op_i == 3'b001) ||
                  (op_i == 3'b100) || (op_i == 3'b110);
        aNeg    = aSigned && rs1Data_i[XLEN-1];
        bNeg    = bSigned && rs2Data_i[XLEN-1];
        aMag    = aNeg ? -rs1Data_i : rs1Data_i;
        bMag    = bNeg ? -rs2Data_i : rs2Data_i;
        divZero = op_i[2] && (rs2Data_i == '0);
        divOvf  = op_i[2] && !op_i[0] && (rs1Data_i == SIGNED_MIN) && (rs2Data_i == '1);
        if (divZero)
            fastRes = op_i[1] ? rs1Data_i : '1;
        else
            fastRes = op_i[1] ? '0 : SIGNED_MIN;
    end

    // One iteration: {hi,lo} is the product register for multiply and the
    // {remainder, dividend/quotient} pair for restoring division.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
        divShift = {hi_q, lo_q[XLEN-1]};
        divDiff  = divShift - {1'b0, addend_q};
        if (op_q[2]) begin
            if (!divDiff[XLEN]) begin
                hi_d = divDiff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = divShift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mulSum[XLEN:1];
            lo_d = {mulSum[0], lo_q[XLEN-1:1]};
        end
        prodFinal = negRes_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        quoFinal  = negRes_q ? -lo_d : lo_d;
        remFinal  = negRem_q ? -hi_d : hi_d;
        unique case (op_q)
            3'b000:                 finalRes = prodFinal[XLEN-1:0];
            3'b001, 3'b010, 3'b011: finalRes = prodFinal[2*XLEN-1:XLEN];
            3'b100, 3'b101:         finalRes = quoFinal;
            default:                finalRes = remFinal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            rdCap_q  <= '0;
            rdOut_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            addend_q <= '0;
            result_q <= '0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
        end else if (kill_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q     <= op_i;
                        rdCap_q  <= rdIn_i;
                        count_q  <= '0;
                        hi_q     <= '0;
                        negRes_q <= aNeg ^ bNeg;
                        negRem_q <= aNeg;
                        addend_q <= op_i[2] ? bMag : aMag;
                        lo_q     <= op_i[2] ? aMag : bMag;
                        if (divZero || divOvf) begin
                            result_q <= fastRes;
                            rdOut_q  <= rdIn_i;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(XLEN-1)) begin
                        result_q <= finalRes;
                        rdOut_q  <= rdCap_q;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign result_o   = result_q;
    assign rdOut_o    = rdOut_q;
    assign wbEnable_o = done_o && (rdOut_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results come from a behavioural
// RV32M model and are queued at issue, then popped when done appears.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [4:0]  rdIn;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rdOut;
    logic        wbEnable;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          startCyc = 0;
    int          busyRun  = 0;
    logic [31:0] lastRes  = '0;
    logic [4:0]  lastRd   = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .kill_i     (kill),
        .op_i       (op),
        .rs1Data_i  (rs1Data),
        .rs2Data_i  (rs2Data),
        .rdIn_i     (rdIn),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .rdOut_o    (rdOut),
        .wbEnable_o (wbEnable)
    );

    // Behavioural RV32M reference using wide native arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] fop, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        int          ia;
        int          ib;
        logic [31:0] r;
        ia = a;
        ib = b;
        r  = '0;
        case (fop)
            3'd0: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[31:0];  end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});       r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};                                r = p[63:32]; end
            3'd4: if (b == 0) r = '1; else if (a == 32'h80000000 && b == '1) r = a; else r = ia / ib;
            3'd5: if (b == 0) r = '1; else r = a / b;
            3'd6: if (b == 0) r = a;  else if (a == 32'h80000000 && b == '1) r = '0; else r = ia % ib;
            default: if (b == 0) r = a; else r = a % b;
        endcase
        return r;
    endfunction

    function automatic int refLatency(input logic [2:0] fop, input logic [31:0] a,
                                      input logic [31:0] b);
        if (fop[2] && (b == 0 || (!fop[0] && a == 32'h80000000 && b == '1)))
            return 1;
        return 33;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (busy) busyRun++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] sop, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input bit push);
        exp_t e;
        op       = sop;
        rs1Data  = a;
        rs2Data  = b;
        rdIn     = rd;
        start    = 1'b1;
        startCyc = cyc;
        busyRun  = 0;
        if (push) begin
            e.res = refModel(sop, a, b);
            e.rd  = rd;
            e.lat = refLatency(sop, a, b);
            sb.push_back(e);
        end
        tick();
        start   = 1'b0;
        rs1Data = $urandom;
        rs2Data = $urandom;
        rdIn    = 5'($urandom);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        lat  = 0;
        if (sb.size() == 0) begin
            check({tag, " scoreboard entry"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < 80 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                lat  = cyc - startCyc;
            end else begin
                tick();
            end
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " busy cycles"}, 32'(busyRun), 32'(e.lat));
        check({tag, " result"}, result, e.res);
        check({tag, " rd_out"}, 32'(rdOut), 32'(e.rd));
        check({tag, " wb_enable"}, 32'(wbEnable), 32'(e.rd != 0));
        lastRes = e.res;
        lastRd  = e.rd;
        tick();
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " busy after done"}, 32'(busy), 32'd0);
        check({tag, " result hold"}, result, e.res);
    endtask

    // Watchdog in case a step hangs outside a bounded wait.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int doneCnt;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst     = 1'b1;
        start   = 1'b0;
        kill    = 1'b0;
        op      = '0;
        rs1Data = '0;
        rs2Data = '0;
        rdIn    = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset wb_enable", 32'(wbEnable), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rdOut), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5, 1'b1);
        checkOutput("MUL 7*-3");
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1);
        checkOutput("MULH");
        applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b1);
        checkOutput("MULHSU");
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1);
        checkOutput("MULHU");
        applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 1'b1);
        checkOutput("DIV -7/2");
        applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 1'b1);
        checkOutput("REM -7/2");
        applyStimulus(3'd5, 32'hFFFFFFF9, 32'd2, 5'd7, 1'b1);
        checkOutput("DIVU");
        applyStimulus(3'd7, 32'd100, 32'd7, 5'd8, 1'b1);
        checkOutput("REMU 100/7");
        applyStimulus(3'd5, 32'd100, 32'd0, 5'd9, 1'b1);
        checkOutput("DIVU by zero");
        applyStimulus(3'd6, 32'd100, 32'd0, 5'd10, 1'b1);
        checkOutput("REM by zero");
        applyStimulus(3'd4, 32'h00000005, 32'd0, 5'd11, 1'b1);
        checkOutput("DIV by zero");
        applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 1'b1);
        checkOutput("DIV overflow");
        applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 1'b1);
        checkOutput("REM overflow");
        applyStimulus(3'd6, 32'd7, 32'hFFFFFFFE, 5'd14, 1'b1);
        checkOutput("REM 7/-2");

        for (int i = 0; i < 8; i++) begin
            rop = 3'(i);
            ra  = $urandom;
            rb  = $urandom;
            applyStimulus(rop, ra, rb, 5'(i + 16), 1'b1);
            checkOutput("random op");
        end

        // A second start mid-calculation must not disturb the running op.
        applyStimulus(3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd15, 1'b1);
        repeat (10) tick();
        op      = 3'd4;
        rs1Data = 32'd1000;
        rs2Data = 32'd3;
        rdIn    = 5'd20;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checkOutput("start while busy");

        applyStimulus(3'd0, 32'd123, 32'd456, 5'd11, 1'b0);
        repeat (20) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill busy drop", 32'(busy), 32'd0);
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) doneCnt++;
            tick();
        end
        check("kill no done", 32'(doneCnt), 32'd0);
        check("kill result kept", result, lastRes);
        check("kill rd_out kept", 32'(rdOut), 32'(lastRd));

        applyStimulus(3'd0, 32'd3, 32'd4, 5'd0, 1'b1);
        checkOutput("MUL rd zero");

        applyStimulus(3'd4, 32'd1000, 32'd7, 5'd12, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-calc reset busy", 32'(busy), 32'd0);
        check("mid-calc reset done", 32'(done), 32'd0);
        check("mid-calc reset wb_enable", 32'(wbEnable), 32'd0);
        check("mid-calc reset result", result, 32'd0);
        check("mid-calc reset rd_out", 32'(rdOut), 32'd0);
        applyStimulus(3'd4, 32'hFFFFFC18, 32'd7, 5'd21, 1'b1);
        checkOutput("DIV after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit, directly downstream of the register file.
- Consumes the rs1/rs2 read data and the decoded funct3 and rd; produces a result and write-back request that return to the register file write port.
- Upstream issue logic stalls on busy; the unit pulses done for one cycle when the result is valid.

Parameters:
- XLEN, 32, operand/result width (design and Test Plan assume 32).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only when state is IDLE.
- kill  in  1  synchronous abort (pipeline flush).
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  XLEN  operand A (multiplicand/dividend).
- rs2_data  in  XLEN  operand B (multiplier/divisor).
- rd_in  in  REG_AW  destination register.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, result valid.
- result  out  XLEN  computed value.
- rd_out  out  REG_AW  destination captured at start.
- wb_enable  out  1  done && (rd_out != 0).

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=1 at edge): state=IDLE, count=0. busy=0, done=0, wb_enable=0, result=0, rd_out=0. Reset mid-CALC or mid-DONE aborts with no done pulse. rst has priority over kill and start.
- kill=1 at edge: state -> IDLE, no done. result and rd_out keep their prior values. kill has priority over start.
- IDLE + start at edge E0:
  - Capture op, rd_in, and operand magnitudes and signs.
  - Signed treatment: MUL/MULH/DIV/REM both operands signed. MULHSU: A signed, B unsigned. MULHU/DIVU/REMU: both unsigned.
  - Normal case: count=0, state -> CALC.
  - Fast paths (no CALC; DONE at E0+1 edge, i.e. done visible the cycle after E0):
    - Divide by zero: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=rs1_data.
    - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV result=0x80000000, REM result=0.
- CALC: one radix-2 iteration per edge, count++. After the 32nd iteration (edge E32) state -> DONE.
  - Multiply: unsigned shift-add into a 64-bit product of magnitudes. Negate the product if exactly one operand was negative.
  - Divide: restoring division on magnitudes. Negate the quotient if the operand signs differ. The remainder takes the dividend's sign.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - The final result is registered on entry to DONE.
- DONE (exactly one cycle): done=1, result and rd_out valid, wb_enable per rd_out. Next edge -> IDLE.
- Normal latency: start seen at E0, done high in the cycle following E32 (33 cycles after the start cycle). busy high from E0+1 through the DONE cycle inclusive.
- start while busy (CALC or DONE) is ignored. Operands are not re-sampled, and upstream must hold the request.
- result and rd_out hold their values after DONE until the next completed operation.
- Operand inputs are don't-care after E0.

Test Plan:
- MUL 7 × (−3) (0x00000007, 0xFFFFFFFD), rd=5 -> busy 33 cycles incl. DONE; done pulse 33 cycles after start; result=0xFFFFFFEB, rd_out=5, wb_enable=1.
- MULH/MULHSU/MULHU with A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE respectively.
- DIV −7/2 -> result 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIVU 100/0 -> done the cycle after start, result=0xFFFFFFFF; REM 100/0 -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 fast path.
- Assert start again at count=10 with different operands -> ignored, original result delivered. Assert kill at count=20 -> busy drops next cycle, no done, prior result unchanged. rd_in=0 -> done=1, wb_enable=0.
- Assert rst during CALC -> all outputs 0 next cycle. A new start immediately after produces the correct result with full latency.
